// File: rtl/tick_countdown_timer.sv
// MM:SS BCD countdown timer clocked by clk, advanced by rising edges of the
// asynchronous divider output tick_in, with load/start/pause/clear strobes.
module tick_countdown_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic        expired,
    output logic        load_err,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_tick_pulse;

    state_t                 r_state;
    logic   [15:0]          r_time;
    logic   [7:0]           r_presc;
    logic                   r_done;
    logic                   r_err;
    logic                   r_expired;
    logic                   r_running;

    state_t                 w_state_next;
    logic   [15:0]          w_time_next;
    logic   [7:0]           w_presc_next;
    logic                   w_done_next;
    logic                   w_err_next;
    logic   [15:0]          w_dec;

    // Digit order {min_tens, min_units, sec_tens, sec_units}.
    function automatic logic bcd_valid(input logic [15:0] v);
        return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
               (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9);
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic       b;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        d3 = v[15:12];
        if (d0 == 4'd0) begin
            d0 = 4'd9;
            b  = 1'b1;
        end else begin
            d0 = d0 - 4'd1;
            b  = 1'b0;
        end
        if (b) begin
            if (d1 == 4'd0) begin
                d1 = 4'd5;
            end else begin
                d1 = d1 - 4'd1;
                b  = 1'b0;
            end
        end
        if (b) begin
            if (d2 == 4'd0) begin
                d2 = 4'd9;
            end else begin
                d2 = d2 - 4'd1;
                b  = 1'b0;
            end
        end
        // A zero count never reaches here in RUN, so min_tens cannot wrap.
        if (b) begin
            d3 = d3 - 4'd1;
        end
        return {d3, d2, d1, d0};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Strobe priority clear > load > start > pause; an accepted strobe
    // swallows any decrement step that lands in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_time_next  = r_time;
        w_presc_next = r_presc;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        w_dec        = bcd_dec(r_time);
        if (clear) begin
            w_state_next = ST_IDLE;
            w_time_next  = 16'h0000;
            w_presc_next = 8'd0;
        end else if (load && (r_state != ST_RUN)) begin
            if (bcd_valid(load_value)) begin
                w_state_next = ST_IDLE;
                w_time_next  = load_value;
                w_presc_next = 8'd0;
            end else begin
                w_err_next = 1'b1;
            end
        end else if (start && ((r_state == ST_IDLE) || (r_state == ST_PAUSED)) &&
                     (r_time != 16'h0000)) begin
            w_state_next = ST_RUN;
            if (r_state == ST_IDLE) begin
                w_presc_next = 8'd0;
            end
        end else if (pause && (r_state == ST_RUN)) begin
            w_state_next = ST_PAUSED;
        end else if ((r_state == ST_RUN) && w_tick_pulse) begin
            if (r_presc == PRESC_LAST) begin
                w_presc_next = 8'd0;
                w_time_next  = w_dec;
                if (w_dec == 16'h0000) begin
                    w_state_next = ST_EXPIRED;
                    w_done_next  = 1'b1;
                end
            end else begin
                w_presc_next = r_presc + 8'd1;
            end
        end
    end

    // expired trails entry into EXPIRED by one cycle so it never overlaps done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_time    <= 16'h0000;
            r_presc   <= 8'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_expired <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_time    <= w_time_next;
            r_presc   <= w_presc_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
            r_expired <= (r_state == ST_EXPIRED) && (w_state_next == ST_EXPIRED);
            r_running <= (w_state_next == ST_RUN);
        end
    end

    assign time_bcd    = r_time;
    assign running     = r_running;
    assign done        = r_done;
    assign expired     = r_expired;
    assign load_err    = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Directed bench for tick_countdown_timer: strobe vector table plus
// multi-cycle sequences for ticking, borrow, pause/resume and reset.
module tb_tick_countdown_timer;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick_in;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        pause;
    logic        clear;

    logic [15:0] d1_time;
    logic        d1_running;
    logic        d1_done;
    logic        d1_expired;
    logic        d1_err;
    logic [1:0]  d1_state;

    logic [15:0] d3_time;
    logic        d3_running;
    logic        d3_done;
    logic        d3_expired;
    logic        d3_err;
    logic [1:0]  d3_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        st;
        logic        pa;
        logic        cl;
        logic [15:0] e_time;
        logic        e_run;
        logic        e_err;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs[18];

    tick_countdown_timer #(.SYNC_STAGES(2), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .load(load),
        .load_value(load_value), .start(start), .pause(pause), .clear(clear),
        .time_bcd(d1_time), .running(d1_running), .done(d1_done),
        .expired(d1_expired), .load_err(d1_err), .o_dbg_state(d1_state)
    );

    tick_countdown_timer #(.SYNC_STAGES(2), .TICK_DIV(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .load(load),
        .load_value(load_value), .start(start), .pause(pause), .clear(clear),
        .time_bcd(d3_time), .running(d3_running), .done(d3_done),
        .expired(d3_expired), .load_err(d3_err), .o_dbg_state(d3_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d1_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic ld, input logic [15:0] lv, input logic st,
                          input logic pa, input logic cl);
        @(posedge clk);
        #1;
        load = ld; load_value = lv; start = st; pause = pa; clear = cl;
        @(posedge clk);
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic tick_once();
        @(posedge clk);
        #1 tick_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic arm(input logic [15:0] v);
        strobe(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        strobe(1'b1, v, 1'b0, 1'b0, 1'b0);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] bor_in[5];
        logic [15:0] bor_exp[5];
        int          t_change[3];
        int          d0;
        logic        seen;
        logic [15:0] exp_t;

        vecs[0]  = '{1'b1, 16'h0070, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, S_IDLE};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, S_IDLE};
        vecs[2]  = '{1'b1, 16'h5959, 1'b0, 1'b0, 1'b0, 16'h5959, 1'b0, 1'b0, S_IDLE};
        vecs[3]  = '{1'b1, 16'h6000, 1'b0, 1'b0, 1'b0, 16'h5959, 1'b0, 1'b1, S_IDLE};
        vecs[4]  = '{1'b1, 16'h0A00, 1'b0, 1'b0, 1'b0, 16'h5959, 1'b0, 1'b1, S_IDLE};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h5959, 1'b1, 1'b0, S_RUN};
        vecs[6]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h5959, 1'b1, 1'b0, S_RUN};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5959, 1'b0, 1'b0, S_PAUSED};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5959, 1'b0, 1'b0, S_PAUSED};
        vecs[9]  = '{1'b1, 16'h0009, 1'b0, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, S_IDLE};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b0, S_RUN};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, S_IDLE};
        vecs[12] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, S_IDLE};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, S_RUN};
        vecs[14] = '{1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, S_RUN};
        vecs[15] = '{1'b1, 16'h0500, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, S_PAUSED};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, S_IDLE};
        vecs[17] = '{1'b1, 16'h0F00, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, S_IDLE};

        bor_in[0] = 16'h1000; bor_exp[0] = 16'h0959;
        bor_in[1] = 16'h0100; bor_exp[1] = 16'h0059;
        bor_in[2] = 16'h0010; bor_exp[2] = 16'h0009;
        bor_in[3] = 16'h2000; bor_exp[3] = 16'h1959;
        bor_in[4] = 16'h0001; bor_exp[4] = 16'h0000;

        // Clock/reset
        reset_n = 1'b0; tick_in = 1'b0; load = 1'b0; load_value = 16'h0000;
        start = 1'b0; pause = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_time", d1_time, 16'h0000);
        check("rst_running", d1_running, 1'b0);
        check("rst_done", d1_done, 1'b0);
        check("rst_expired", d1_expired, 1'b0);
        check("rst_err", d1_err, 1'b0);
        check("rst_state", d1_state, S_IDLE);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Strobe vector table
        for (int i = 0; i < 18; i++) begin
            strobe(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa, vecs[i].cl);
            @(negedge clk);
            check($sformatf("vec%0d_time", i), d1_time, vecs[i].e_time);
            check($sformatf("vec%0d_running", i), d1_running, vecs[i].e_run);
            check($sformatf("vec%0d_err", i), d1_err, vecs[i].e_err);
            check($sformatf("vec%0d_state", i), d1_state, vecs[i].e_state);
            check($sformatf("vec%0d_done", i), d1_done, 1'b0);
        end

        // Reset in the middle of a count
        arm(16'h0003);
        tick_once();
        @(negedge clk);
        check("midrst_pre_time", d1_time, 16'h0002);
        d0 = done_cnt;
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("midrst_time", d1_time, 16'h0000);
        check("midrst_running", d1_running, 1'b0);
        check("midrst_state", d1_state, S_IDLE);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst_after_time", d1_time, 16'h0000);
        check("midrst_after_state", d1_state, S_IDLE);
        check("midrst_no_done", done_cnt, d0);

        // Basic count 0003 -> 0000 with a rising tick edge every 20 clocks
        arm(16'h0003);
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_t = 16'(2 - i);
            t_change[i] = 0;
            @(posedge clk);
            #1 tick_in = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (!seen && d1_time == exp_t) begin
                    seen = 1'b1;
                    t_change[i] = cyc;
                    check($sformatf("basic%0d_done", i), d1_done, (i == 2));
                    check($sformatf("basic%0d_expired_early", i), d1_expired, 1'b0);
                end
            end
            check($sformatf("basic%0d_step_seen", i), seen, 1'b1);
            @(posedge clk);
            #1 tick_in = 1'b0;
            repeat (9) @(posedge clk);
        end
        check("basic_spacing01", t_change[1] - t_change[0], 20);
        check("basic_spacing12", t_change[2] - t_change[1], 20);
        check("basic_done_once", done_cnt - d0, 1);
        check("basic_expired", d1_expired, 1'b1);
        check("basic_running", d1_running, 1'b0);
        check("basic_state", d1_state, S_EXPIRED);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("exp_start_ignored", d1_state, S_EXPIRED);
        strobe(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("exp_load_expired", d1_expired, 1'b0);
        check("exp_load_state", d1_state, S_IDLE);
        check("exp_load_time", d1_time, 16'h0010);

        // BCD borrow chain
        for (int i = 0; i < 5; i++) begin
            arm(bor_in[i]);
            tick_once();
            @(negedge clk);
            check($sformatf("borrow_%h", bor_in[i]), d1_time, bor_exp[i]);
        end

        // Pause/resume: prescaler of the TICK_DIV=3 instance must be held
        arm(16'h0005);
        tick_once();
        tick_once();
        strobe(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        repeat (5) tick_once();
        @(negedge clk);
        check("pause_div3_time", d3_time, 16'h0005);
        check("pause_div3_state", d3_state, S_PAUSED);
        check("pause_div1_time", d1_time, 16'h0003);
        strobe(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        tick_once();
        @(negedge clk);
        check("resume_div3_time", d3_time, 16'h0004);
        check("resume_div1_time", d1_time, 16'h0002);
        check("resume_div3_running", d3_running, 1'b1);

        // Pause lands on the same edge as a decrement step
        arm(16'h0005);
        @(posedge clk);
        #1 tick_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 pause = 1'b1;
        @(posedge clk);
        #1 pause = 1'b0;
        @(negedge clk);
        check("coinc_pause_state", d1_state, S_PAUSED);
        check("coinc_pause_time", d1_time, 16'h0005);
        repeat (10) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("coinc_pause_hold", d1_time, 16'h0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
